// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: reset/queue defaults, entry layout
// and pointer sizing.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0001_0000;
  localparam int          QDEPTH_DEF   = 4;
  localparam int          ADDR_W       = 30;
  localparam int          INSN_W       = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INSN_W-1:0] data;
    logic              err;
    logic              filled;
  } q_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_pc_queue_if.sv
// Fetch-side bus: icache request/response channel and decode delivery channel.
interface fetch_pc_queue_if;
  import fetch_pkg::*;

  // A request transfers in any cycle with fetch_ic_req=1 (req already implies
  // icache_ready); a decode transfer happens when fetch_de_valid & decode_ready.
  logic              fetch_ic_req;
  logic [ADDR_W-1:0] fetch_ic_addr;
  logic              fetch_ic_flush;
  logic              icache_ready;
  logic              icache_valid;
  logic              icache_error;
  logic [INSN_W-1:0] icache_data;
  logic              fetch_de_valid;
  logic [INSN_W-1:0] fetch_de_insn;
  logic [ADDR_W-1:0] fetch_de_addr;
  logic              fetch_de_error;
  logic              decode_ready;

  modport master (
    output fetch_ic_req, fetch_ic_addr, fetch_ic_flush,
    input  icache_ready, icache_valid, icache_error, icache_data,
    output fetch_de_valid, fetch_de_insn, fetch_de_addr, fetch_de_error,
    input  decode_ready
  );

  modport slave (
    input  fetch_ic_req, fetch_ic_addr, fetch_ic_flush,
    output icache_ready, icache_valid, icache_error, icache_data,
    input  fetch_de_valid, fetch_de_insn, fetch_de_addr, fetch_de_error,
    output decode_ready
  );

endinterface

// File: rtl/fetch_pc_queue_queue.sv
// In-order reserve/fill/dequeue circular buffer with flush. An entry is reserved
// at issue time and filled when its icache response returns.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                QDEPTH     = QDEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_PC_DEF[31:2]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              rsv_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              fill_i,
  input  logic [INSN_W-1:0] fill_data_i,
  input  logic              fill_err_i,
  input  logic              deq_i,
  output logic              full_o,
  output logic              head_valid_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [INSN_W-1:0] head_data_o,
  output logic              head_err_o
);

  localparam int          PW    = ptr_w(QDEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(QDEPTH);
  localparam logic [PW-1:0] P1  = PW'(1);
  localparam logic [PW:0] C1    = (PW+1)'(1);

  q_entry_t        ent_q [QDEPTH];
  logic [PW-1:0]   head_q, tail_q, fill_q;
  logic [PW:0]     count_q, count_d;
  q_entry_t        head;

  always_comb begin
    count_d = count_q;
    if (rsv_i && !deq_i)      count_d = count_q + C1;
    else if (!rsv_i && deq_i) count_d = count_q - C1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++)
        ent_q[i] <= '{addr: RESET_ADDR, data: '0, err: 1'b0, filled: 1'b0};
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++)
        ent_q[i].filled <= 1'b0;
    end else begin
      // Reserve and fill never target the same slot: fill only walks reserved entries.
      if (rsv_i) begin
        ent_q[tail_q].addr   <= rsv_addr_i;
        ent_q[tail_q].filled <= 1'b0;
        tail_q               <= tail_q + P1;
      end
      if (fill_i) begin
        ent_q[fill_q].data   <= fill_data_i;
        ent_q[fill_q].err    <= fill_err_i;
        ent_q[fill_q].filled <= 1'b1;
        fill_q               <= fill_q + P1;
      end
      if (deq_i) head_q <= head_q + P1;
      count_q <= count_d;
    end
  end

  assign head         = ent_q[head_q];
  assign full_o       = (count_q == FULL);
  assign head_valid_o = (count_q != '0) && head.filled;
  assign head_addr_o  = head.addr;
  assign head_data_o  = head.data;
  assign head_err_o   = head.err;

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch stage top: PC, issue gating, redirect control and optional halt-on-fault
// (enabled by defining FETCH_HALT_ON_ERROR_EN).
module fetch_pc_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = QDEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_pc_queue_if.master   bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted;
  logic              issue, fill, deq;
  logic              full, head_valid;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue looks at the registered count only, so a full queue blocks issue even
  // in a cycle where decode frees a slot.
  assign issue = ~rst & ~redirect & bus.icache_ready & ~full & ~halted;
  assign fill  = bus.icache_valid & ~redirect;
  assign deq   = head_valid & bus.decode_ready & ~redirect;

  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = redirect_pc[31:2];
    else if (issue) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC[31:2];
    else     pc_q <= pc_d;
  end

`ifdef FETCH_HALT_ON_ERROR_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect)                       halted_d = 1'b0;
    else if (fill && bus.icache_error)  halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  fetch_queue #(
    .QDEPTH     (QDEPTH),
    .RESET_ADDR (RESET_PC[31:2])
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .rsv_i        (issue),
    .rsv_addr_i   (pc_q),
    .fill_i       (fill),
    .fill_data_i  (bus.icache_data),
    .fill_err_i   (bus.icache_error),
    .deq_i        (deq),
    .full_o       (full),
    .head_valid_o (head_valid),
    .head_addr_o  (bus.fetch_de_addr),
    .head_data_o  (bus.fetch_de_insn),
    .head_err_o   (bus.fetch_de_error)
  );

  assign bus.fetch_ic_req   = issue;
  assign bus.fetch_ic_addr  = pc_q;
  assign bus.fetch_ic_flush = redirect & ~rst;
  assign bus.fetch_de_valid = head_valid;

endmodule
